// File: rtl/oneshot_multi.sv
// N-channel synchronous one-shot: synchronised trigger edge -> programmable delay, pulse, hold-off.
// Retrigger is either ignored or restarts the current phase; dropped triggers set a sticky flag.
module oneshot_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       trig_in,
    input  logic [NCH*WIDTH-1:0] pulse_width,
    input  logic [NCH*WIDTH-1:0] pulse_delay,
    input  logic [WIDTH-1:0]     holdoff,
    input  logic                 retrig_mode,
    input  logic [NCH-1:0]       miss_clr,
    output logic [NCH-1:0]       pulse_out,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       missed
);

    typedef enum logic [1:0] {StIdle, StDelay, StPulse, StHold} state_t;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   edge_q;
        state_t                 state_q;
        logic [WIDTH-1:0]       cnt_q;
        logic [WIDTH-1:0]       w_q;
        logic                   pulse_q;
        logic                   busy_q;
        logic                   missed_q;
        logic [WIDTH-1:0]       cfg_w;
        logic [WIDTH-1:0]       cfg_d;
        logic                   ev;
        logic                   restart;
        logic                   drop;

        assign cfg_w = pulse_width[c*WIDTH +: WIDTH];
        assign cfg_d = pulse_delay[c*WIDTH +: WIDTH];
        assign ev    = sync_q[SYNC_STAGES-1] & ~edge_q;

        // Restart only re-arms DELAY/PULSE with a usable width; everything else while busy drops.
        assign restart = ev & retrig_mode & (cfg_w != '0) &
                         ((state_q == StDelay) || (state_q == StPulse));
        assign drop    = ev & en[c] & (state_q != StIdle) & ~restart;

        assign pulse_out[c] = pulse_q;
        assign busy[c]      = busy_q;
        assign missed[c]    = missed_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q   <= '0;
                edge_q   <= 1'b0;
                state_q  <= StIdle;
                cnt_q    <= '0;
                w_q      <= '0;
                pulse_q  <= 1'b0;
                busy_q   <= 1'b0;
                missed_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in[c]};
                edge_q <= sync_q[SYNC_STAGES-1];

                // Set has priority over clear.
                if (drop) begin
                    missed_q <= 1'b1;
                end else if (miss_clr[c]) begin
                    missed_q <= 1'b0;
                end

                if (!en[c]) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (ev && (cfg_w != '0)) begin
                                w_q    <= cfg_w;
                                busy_q <= 1'b1;
                                if (cfg_d == '0) begin
                                    state_q <= StPulse;
                                    cnt_q   <= cfg_w - One;
                                    pulse_q <= 1'b1;
                                end else begin
                                    state_q <= StDelay;
                                    cnt_q   <= cfg_d - One;
                                end
                            end
                        end
                        StDelay: begin
                            if (restart) begin
                                w_q <= cfg_w;
                                if (cfg_d == '0) begin
                                    state_q <= StPulse;
                                    cnt_q   <= cfg_w - One;
                                    pulse_q <= 1'b1;
                                end else begin
                                    cnt_q <= cfg_d - One;
                                end
                            end else if (cnt_q == '0) begin
                                state_q <= StPulse;
                                cnt_q   <= w_q - One;
                                pulse_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - One;
                            end
                        end
                        StPulse: begin
                            if (restart) begin
                                w_q   <= cfg_w;
                                cnt_q <= cfg_w - One;
                            end else if (cnt_q == '0) begin
                                pulse_q <= 1'b0;
                                if (holdoff != '0) begin
                                    state_q <= StHold;
                                    cnt_q   <= holdoff - One;
                                end else begin
                                    state_q <= StIdle;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                cnt_q <= cnt_q - One;
                            end
                        end
                        StHold: begin
                            if (cnt_q == '0) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - One;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/oneshot_multi.md
Name: oneshot_multi

Overview:
- N-channel, clock-synchronous successor to the dynamic one-shot.
- Each channel synchronises an asynchronous trigger and detects its rising edge. It then emits one pulse with a programmable delay and width, followed by an optional hold-off (dead time).
- Retrigger mode is selectable. Dropped triggers are flagged.
- Sits between the discriminator outputs and the gating/timing logic of the photon channels.

Parameters:
- NCH, 4, number of independent channels
- WIDTH, 5, bit width of the delay, width and hold-off values
- SYNC_STAGES, 2, trigger synchroniser depth (legal range 2..4)

Ports:
- clk  in  1  sole clock; all state changes on posedge clk
- rst_n  in  1  asynchronous, active-low reset
- en  in  NCH  per-channel enable
- trig_in  in  NCH  asynchronous triggers; rising edge is the event
- pulse_width  in  NCH*WIDTH  per-channel width in cycles; channel c uses bits [c*WIDTH +: WIDTH]
- pulse_delay  in  NCH*WIDTH  per-channel delay in cycles; same packing
- holdoff  in  WIDTH  shared dead time after each pulse, in cycles
- retrig_mode  in  1  shared; 0 = IGNORE, 1 = RESTART
- miss_clr  in  NCH  per-channel clear of the missed flag
- pulse_out  out  NCH  registered pulse outputs
- busy  out  NCH  high whenever the channel is not IDLE
- missed  out  NCH  sticky flag: a trigger was dropped

Behaviour:
- Reset (rst_n low, asynchronous):
  - all synchroniser flops, edge-detect flops and counters clear to 0
  - all channel states go to IDLE
  - pulse_out = 0, busy = 0, missed = 0
- Trigger path:
  - trig_in[c] passes through SYNC_STAGES flops, then a rising-edge detector (sync & ~sync_d).
  - A trig_in held high through reset release produces one edge after release.
  - Latency: first sampling edge t0 → event seen by the FSM at edge t0+SYNC_STAGES.
- Channel FSM states: IDLE, DELAY, PULSE, HOLD. cnt is WIDTH bits.
- Acceptance in IDLE:
  - On an edge event with en[c] = 1, latch w = pulse_width[c] and d = pulse_delay[c].
  - w == 0 → event ignored; stay IDLE; missed is not set.
  - d == 0 → go to PULSE, cnt = w-1.
  - d > 0 → go to DELAY, cnt = d-1.
  - Config changes after acceptance do not affect the current pulse.
- DELAY: if cnt == 0 → PULSE with cnt = w-1; else decrement cnt.
- PULSE:
  - pulse_out[c] is registered high in this state only.
  - If cnt == 0: go to HOLD with cnt = holdoff-1 if holdoff > 0, else go to IDLE. Otherwise decrement cnt.
- HOLD: if cnt == 0 → IDLE; else decrement cnt. holdoff is sampled on entry to HOLD.
- Resulting timing:
  - pulse_out rises after edge t0+SYNC_STAGES+d.
  - pulse_out is high for exactly w cycles.
  - busy covers d + w + holdoff cycles.
- Event while not IDLE:
  - IGNORE mode: dropped; missed[c] set.
  - RESTART mode, in DELAY: cnt reloaded with d-1 using newly latched values (w == 0 → dropped, missed set).
  - RESTART mode, in PULSE: cnt reloaded with w-1 using newly latched values (w == 0 → dropped, missed set); the pulse stays continuous with no low cycle.
  - RESTART mode, in HOLD: dropped; missed set.
- The last cycle of PULSE/HOLD counts as busy: an event in that cycle follows the busy rules, not the IDLE rules.
- missed[c]: set and miss_clr[c] in the same cycle → stays set (set wins).
- en[c] low: synchronous abort to IDLE. pulse_out, busy and cnt clear on the next edge. Events are ignored and do not set missed. The synchroniser keeps running.
- Counters never wrap: every load is the value minus 1 and is guarded by a nonzero check.
- Width/delay value 2^WIDTH-1 is legal and gives the maximum duration.
- Reset asserted mid-operation: immediate return to the reset values above.

Test Plan:
1. Basic pulse. NCH = 4, SYNC_STAGES = 2, ch0 w = 5, d = 0, holdoff = 0; trig_in[0] rises before edge 10 → pulse_out[0] high after edges 12..16 (5 cycles); busy[0] identical.
2. Delay and hold-off. ch1 w = 3, d = 4, holdoff = 6; trigger sampled at edge 20 → pulse_out[1] high after edges 26..28; busy[1] high after 22..34; a second trigger at edge 30 sets missed[1] and gives no pulse.
3. Retrigger modes. ch2 w = 8. Mode IGNORE: re-trigger 3 cycles into the pulse → 8-cycle pulse, missed[2] = 1. Mode RESTART: same stimulus → single continuous 11-cycle pulse, missed[2] = 0.
4. Edge cases. w = 0 → no pulse, busy stays 0, missed stays 0. w = 31 (WIDTH = 5) → 31-cycle pulse, no wrap. pulse_width changed mid-pulse → current pulse length unchanged.
5. Abort and reset. Drop en[3] mid-pulse → pulse_out[3] low after the next edge. Assert rst_n low asynchronously mid-pulse → all outputs 0 immediately, without waiting for a clock edge.
6. Flag and channel isolation. miss_clr[1] together with a dropped trigger in the same cycle → missed[1] stays 1. Simultaneous triggers on all 4 channels → independent pulses with no cross-channel effect.
